ex_mem_stage: RTL and testbench

- Execute-to-memory pipeline stage directly downstream of the 16-bit ALU.
- Consumes the ALU result and flags (out, cOut, zero, gZero) and resolves set-condition instructions (SEQ/SLT/SLE/SCO) and conditional branches/jumps.
- Registers the result with the memory/writeback controls into the EX/MEM latch, with stall, flush, one-shot redirect and a sticky illegal-control flag.

---
 rtl/ex_mem_stage.sv | 147 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline latch downstream of the 16-bit ALU: resolves set-condition and
// branch outcomes, registers memory/writeback controls, and drives a one-shot fetch redirect.
module ex_mem_stage #(
    parameter int WIDTH = 16,
    parameter int REG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout,
    input  logic             alu_zero,
    input  logic             alu_gzero,
    input  logic [2:0]       cond_op,
    input  logic             is_branch,
    input  logic [1:0]       br_op,
    input  logic             is_jump,
    input  logic [WIDTH-1:0] br_target,
    input  logic [WIDTH-1:0] pc_plus2,
    input  logic             wr_en_in,
    input  logic [REG_W-1:0] wr_reg_in,
    input  logic             mem_rd_in,
    input  logic             mem_wr_in,
    input  logic [WIDTH-1:0] store_data_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             wr_en_out,
    output logic [REG_W-1:0] wr_reg_out,
    output logic             mem_rd_out,
    output logic             mem_wr_out,
    output logic [WIDTH-1:0] store_data_out,
    output logic [WIDTH-1:0] pc_link,
    output logic             br_taken,
    output logic             redirect,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             illegal
);

    typedef enum logic {
        IDLE  = 1'b0,
        FIRED = 1'b1
    } redir_state_t;

    localparam logic [2:0] COND_NONE = 3'b000;
    localparam logic [2:0] COND_SEQ  = 3'b001;
    localparam logic [2:0] COND_SLT  = 3'b010;
    localparam logic [2:0] COND_SLE  = 3'b011;
    localparam logic [2:0] COND_SCO  = 3'b100;

    localparam logic [1:0] BR_BEQZ = 2'b00;
    localparam logic [1:0] BR_BNEZ = 2'b01;
    localparam logic [1:0] BR_BLTZ = 2'b10;
    localparam logic [1:0] BR_BGEZ = 2'b11;

    redir_state_t     state;
    logic [WIDTH-1:0] next_result;
    logic             br_cond;
    logic             taken;
    logic             bad_ctl;

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_result = alu_out;
        case (cond_op)
            COND_NONE: next_result = alu_out;
            COND_SEQ:  next_result = {{(WIDTH-1){1'b0}}, alu_zero};
            COND_SLT:  next_result = {{(WIDTH-1){1'b0}}, alu_gzero};
            COND_SLE:  next_result = {{(WIDTH-1){1'b0}}, alu_gzero | alu_zero};
            COND_SCO:  next_result = {{(WIDTH-1){1'b0}}, alu_cout};
            default:   next_result = alu_out;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (br_op)
            BR_BEQZ: br_cond = alu_zero;
            BR_BNEZ: br_cond = ~alu_zero;
            BR_BLTZ: br_cond = ~alu_zero & ~alu_gzero;
            BR_BGEZ: br_cond = alu_gzero | alu_zero;
            default: br_cond = 1'b0;
        endcase
    end

    // A jump is taken regardless of the branch condition.
    assign taken   = in_valid & (is_jump | (is_branch & br_cond));
    assign bad_ctl = in_valid & ((mem_rd_in & mem_wr_in) | ((mem_rd_in | mem_wr_in) & is_branch));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            out_valid      <= 1'b0;
            result         <= '0;
            wr_en_out      <= 1'b0;
            wr_reg_out     <= '0;
            mem_rd_out     <= 1'b0;
            mem_wr_out     <= 1'b0;
            store_data_out <= '0;
            pc_link        <= '0;
            br_taken       <= 1'b0;
            redirect       <= 1'b0;
            redirect_pc    <= '0;
            illegal        <= 1'b0;
        end else if (flush) begin
            // Squash: controls and datapath cleared; the error flag is sticky.
            state          <= IDLE;
            out_valid      <= 1'b0;
            result         <= '0;
            wr_en_out      <= 1'b0;
            wr_reg_out     <= '0;
            mem_rd_out     <= 1'b0;
            mem_wr_out     <= 1'b0;
            store_data_out <= '0;
            pc_link        <= '0;
            br_taken       <= 1'b0;
            redirect       <= 1'b0;
            redirect_pc    <= '0;
        end else if (stall) begin
            // A held entry that already fired must not pulse again.
            redirect <= (state == FIRED) ? 1'b0 : redirect;
        end else begin
            out_valid      <= in_valid;
            result         <= next_result;
            wr_en_out      <= wr_en_in & in_valid;
            wr_reg_out     <= wr_reg_in;
            mem_rd_out     <= mem_rd_in & in_valid;
            mem_wr_out     <= mem_wr_in & in_valid & ~bad_ctl;
            store_data_out <= store_data_in;
            pc_link        <= pc_plus2;
            br_taken       <= taken;
            redirect       <= taken;
            state          <= taken ? FIRED : IDLE;
            if (taken) begin
                redirect_pc <= br_target;
            end
            if (bad_ctl) begin
                illegal <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: the driver pushes the reference model's expected
// output snapshot every clock, and an independent monitor pops and compares it.
module tb_ex_mem_stage;

    localparam int WIDTH = 16;
    localparam int REG_W = 3;

    typedef struct {
        logic             rst_n;
        logic             in_valid;
        logic             stall;
        logic             flush;
        logic [WIDTH-1:0] alu_out;
        logic             alu_cout;
        logic             alu_zero;
        logic             alu_gzero;
        logic [2:0]       cond_op;
        logic             is_branch;
        logic [1:0]       br_op;
        logic             is_jump;
        logic [WIDTH-1:0] br_target;
        logic [WIDTH-1:0] pc_plus2;
        logic             wr_en_in;
        logic [REG_W-1:0] wr_reg_in;
        logic             mem_rd_in;
        logic             mem_wr_in;
        logic [WIDTH-1:0] store_data_in;
    } stim_t;

    typedef struct {
        logic             out_valid;
        logic [WIDTH-1:0] result;
        logic             wr_en_out;
        logic [REG_W-1:0] wr_reg_out;
        logic             mem_rd_out;
        logic             mem_wr_out;
        logic [WIDTH-1:0] store_data_out;
        logic [WIDTH-1:0] pc_link;
        logic             br_taken;
        logic             redirect;
        logic [WIDTH-1:0] redirect_pc;
        logic             illegal;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n, in_valid, stall, flush;
    logic [WIDTH-1:0] alu_out;
    logic             alu_cout, alu_zero, alu_gzero;
    logic [2:0]       cond_op;
    logic             is_branch;
    logic [1:0]       br_op;
    logic             is_jump;
    logic [WIDTH-1:0] br_target, pc_plus2;
    logic             wr_en_in;
    logic [REG_W-1:0] wr_reg_in;
    logic             mem_rd_in, mem_wr_in;
    logic [WIDTH-1:0] store_data_in;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             wr_en_out;
    logic [REG_W-1:0] wr_reg_out;
    logic             mem_rd_out, mem_wr_out;
    logic [WIDTH-1:0] store_data_out, pc_link;
    logic             br_taken, redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             illegal;

    int   checks   = 0;
    int   failures = 0;
    bit   started  = 1'b0;
    exp_t model;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    ex_mem_stage #(.WIDTH(WIDTH), .REG_W(REG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_zero(alu_zero), .alu_gzero(alu_gzero),
        .cond_op(cond_op), .is_branch(is_branch), .br_op(br_op), .is_jump(is_jump),
        .br_target(br_target), .pc_plus2(pc_plus2), .wr_en_in(wr_en_in), .wr_reg_in(wr_reg_in),
        .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in), .store_data_in(store_data_in),
        .out_valid(out_valid), .result(result), .wr_en_out(wr_en_out), .wr_reg_out(wr_reg_out),
        .mem_rd_out(mem_rd_out), .mem_wr_out(mem_wr_out), .store_data_out(store_data_out),
        .pc_link(pc_link), .br_taken(br_taken), .redirect(redirect), .redirect_pc(redirect_pc),
        .illegal(illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the latch must hold after one edge, from the stage's rules.
    function automatic exp_t step(input exp_t cur, input stim_t s);
        exp_t n;
        bit   cond_hit;
        bit   is_neg;
        bit   go;
        bit   mem_any;
        bit   bad;
        n = cur;
        if (!s.rst_n) begin
            n = '{default: '0};
            return n;
        end
        if (s.flush) begin
            n = '{default: '0};
            n.illegal = cur.illegal;
            return n;
        end
        if (s.stall) begin
            n.redirect = 1'b0;
            return n;
        end
        // Set conditions: flag forms a 0/1 result; unused codes pass the ALU value.
        if      (s.cond_op == 3'd1) n.result = WIDTH'(s.alu_zero);
        else if (s.cond_op == 3'd2) n.result = WIDTH'(s.alu_gzero);
        else if (s.cond_op == 3'd3) n.result = WIDTH'(s.alu_gzero || s.alu_zero);
        else if (s.cond_op == 3'd4) n.result = WIDTH'(s.alu_cout);
        else                        n.result = s.alu_out;
        // Branches test Rs: negative means neither zero nor positive.
        is_neg = !s.alu_zero && !s.alu_gzero;
        case (s.br_op)
            2'd0:    cond_hit = s.alu_zero;
            2'd1:    cond_hit = !s.alu_zero;
            2'd2:    cond_hit = is_neg;
            default: cond_hit = !is_neg;
        endcase
        go      = s.in_valid && (s.is_jump || (s.is_branch && cond_hit));
        mem_any = s.mem_rd_in || s.mem_wr_in;
        bad     = s.in_valid && ((s.mem_rd_in && s.mem_wr_in) || (mem_any && s.is_branch));
        n.out_valid      = s.in_valid;
        n.wr_en_out      = s.in_valid && s.wr_en_in;
        n.wr_reg_out     = s.wr_reg_in;
        n.mem_rd_out     = s.in_valid && s.mem_rd_in;
        n.mem_wr_out     = s.in_valid && s.mem_wr_in && !bad;
        n.store_data_out = s.store_data_in;
        n.pc_link        = s.pc_plus2;
        n.br_taken       = go;
        n.redirect       = go;
        if (go)  n.redirect_pc = s.br_target;
        if (bad) n.illegal = 1'b1;
        return n;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: '0};
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim(input bit allow_bad);
        stim_t s;
        s.rst_n         = ($urandom_range(0, 59) != 0);
        s.in_valid      = ($urandom_range(0, 3) != 0);
        s.stall         = ($urandom_range(0, 4) == 0);
        s.flush         = ($urandom_range(0, 11) == 0);
        s.alu_out       = WIDTH'($urandom);
        s.alu_cout      = 1'($urandom);
        s.alu_zero      = 1'($urandom);
        s.alu_gzero     = 1'($urandom);
        s.cond_op       = 3'($urandom);
        s.is_branch     = ($urandom_range(0, 2) == 0);
        s.br_op         = 2'($urandom);
        s.is_jump       = ($urandom_range(0, 5) == 0);
        s.br_target     = WIDTH'($urandom);
        s.pc_plus2      = WIDTH'($urandom);
        s.wr_en_in      = 1'($urandom);
        s.wr_reg_in     = REG_W'($urandom);
        s.mem_rd_in     = ($urandom_range(0, 3) == 0);
        s.mem_wr_in     = ($urandom_range(0, 3) == 0);
        s.store_data_in = WIDTH'($urandom);
        if (!allow_bad) begin
            s.rst_n     = 1'b1;
            s.mem_wr_in = s.mem_wr_in && !s.mem_rd_in;
            if (s.mem_rd_in || s.mem_wr_in) s.is_branch = 1'b0;
        end
        return s;
    endfunction

    // Apply one cycle of stimulus; returns #1 after the edge with the expectation queued.
    task automatic drive(input stim_t s);
        rst_n = s.rst_n; in_valid = s.in_valid; stall = s.stall; flush = s.flush;
        alu_out = s.alu_out; alu_cout = s.alu_cout; alu_zero = s.alu_zero;
        alu_gzero = s.alu_gzero; cond_op = s.cond_op; is_branch = s.is_branch;
        br_op = s.br_op; is_jump = s.is_jump; br_target = s.br_target;
        pc_plus2 = s.pc_plus2; wr_en_in = s.wr_en_in; wr_reg_in = s.wr_reg_in;
        mem_rd_in = s.mem_rd_in; mem_wr_in = s.mem_wr_in; store_data_in = s.store_data_in;
        @(posedge clk);
        model = step(model, s);
        sb_q.push_back(model);
        started = 1'b1;
        #1;
    endtask

    // Monitor: one expected snapshot per clock, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty actual=0 expected=1 at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("out_valid",      32'(out_valid),      32'(e.out_valid));
                    check("result",         32'(result),         32'(e.result));
                    check("wr_en_out",      32'(wr_en_out),      32'(e.wr_en_out));
                    check("wr_reg_out",     32'(wr_reg_out),     32'(e.wr_reg_out));
                    check("mem_rd_out",     32'(mem_rd_out),     32'(e.mem_rd_out));
                    check("mem_wr_out",     32'(mem_wr_out),     32'(e.mem_wr_out));
                    check("store_data_out", 32'(store_data_out), 32'(e.store_data_out));
                    check("pc_link",        32'(pc_link),        32'(e.pc_link));
                    check("br_taken",       32'(br_taken),       32'(e.br_taken));
                    check("redirect",       32'(redirect),       32'(e.redirect));
                    check("illegal",        32'(illegal),        32'(e.illegal));
                    if (e.br_taken) check("redirect_pc", 32'(redirect_pc), 32'(e.redirect_pc));
                end
            end
        end
    end

    initial begin
        stim_t s;
        model = '{default: '0};

        // Reset with every input high, then release into bubbles.
        s = '{default: '1};
        s.rst_n = 1'b0;
        repeat (2) drive(s);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result",    32'(result),    32'd0);
        check("reset_illegal",   32'(illegal),   32'd0);
        s = idle_stim();
        repeat (2) drive(s);

        // SLT writes a 0/1 flag to r5.
        s = idle_stim();
        s.in_valid = 1'b1; s.alu_out = 16'h0003; s.alu_gzero = 1'b1; s.cond_op = 3'b010;
        s.wr_en_in = 1'b1; s.wr_reg_in = 3'd5;
        drive(s);
        check("slt_result", 32'(result),     32'h0001);
        check("slt_wr_reg", 32'(wr_reg_out), 32'd5);

        // SCO and SEQ flag selection.
        s = idle_stim();
        s.in_valid = 1'b1; s.alu_out = 16'h0000; s.alu_cout = 1'b1; s.alu_zero = 1'b1;
        s.cond_op = 3'b100;
        drive(s);
        check("sco_result", 32'(result), 32'h0001);
        s.cond_op = 3'b001;
        drive(s);
        check("seq_true_result", 32'(result), 32'h0001);
        s.alu_out = 16'hFFFE; s.alu_zero = 1'b0;
        drive(s);
        check("seq_false_result", 32'(result), 32'h0000);

        // BLTZ taken, then held by stall: one redirect pulse only.
        s = idle_stim();
        s.in_valid = 1'b1; s.is_branch = 1'b1; s.br_op = 2'b10; s.alu_out = 16'h8000;
        s.br_target = 16'h0040;
        drive(s);
        check("bltz_redirect_first", 32'(redirect), 32'd1);
        s.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(s);
            check("bltz_redirect_held",    32'(redirect),    32'd0);
            check("bltz_taken_held",       32'(br_taken),    32'd1);
            check("bltz_redirect_pc_held", 32'(redirect_pc), 32'h0040);
        end

        // Store held by stall, then flush wins over stall.
        s = idle_stim();
        s.in_valid = 1'b1; s.mem_wr_in = 1'b1; s.alu_out = 16'h1234; s.store_data_in = 16'hBEEF;
        drive(s);
        s.stall = 1'b1;
        drive(s);
        check("store_held_wr", 32'(mem_wr_out), 32'd1);
        s.flush = 1'b1;
        drive(s);
        check("flush_out_valid", 32'(out_valid),  32'd0);
        check("flush_mem_wr",    32'(mem_wr_out), 32'd0);
        check("flush_result",    32'(result),     32'd0);

        // Load+store together is illegal; flag survives clean traffic until reset.
        s = idle_stim();
        s.in_valid = 1'b1; s.mem_rd_in = 1'b1; s.mem_wr_in = 1'b1;
        drive(s);
        check("illegal_set",      32'(illegal),    32'd1);
        check("illegal_no_store", 32'(mem_wr_out), 32'd0);
        for (int i = 0; i < 5; i++) begin
            s = rand_stim(1'b0);
            s.in_valid = 1'b1; s.stall = 1'b0; s.flush = 1'b0;
            drive(s);
        end
        check("illegal_sticky", 32'(illegal), 32'd1);
        s = idle_stim();
        s.rst_n = 1'b0;
        drive(s);
        check("illegal_cleared", 32'(illegal), 32'd0);

        // Randomized traffic including resets, stalls, flushes and bad controls.
        for (int i = 0; i < 3000; i++) begin
            drive(rand_stim(1'b1));
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
